// File: rtl/cp_window_peak_pkg.sv
// Shared receiver package for the cyclic-prefix window peak search.
// Holds the default geometry of the detector, the FSM state type, the
// default-width metric type and a helper producing the most-negative metric
// value for any metric width up to 64 bits.
package cp_window_peak_pkg;

  localparam int DEF_WL_IN   = 20;
  localparam int DEF_CP_LEN  = 16;
  localparam int DEF_SYM_LEN = 272;
  localparam int DEF_WL_ACC  = DEF_WL_IN + $clog2(DEF_CP_LEN);
  localparam int DEF_MET_W   = DEF_WL_ACC + 2;

  typedef logic signed [DEF_MET_W-1:0] metric_t;

  typedef enum logic {
    ST_FILL,
    ST_SEARCH
  } cp_state_e;

  // Most-negative value of a w-bit signed metric, sign-extended to 64 bits.
  // Callers truncate to their own metric width.
  function automatic logic signed [63:0] met_most_neg(input int w);
    return $signed(64'hFFFF_FFFF_FFFF_FFFF << (w - 1));
  endfunction

endpackage

// File: rtl/cp_window_peak_if.sv
// Sample/result bus of the CP window peak detector.
//   in_valid                         : sample strobe from the metric precalc
//   corr_real_in/corr_imag_in        : per-sample lag correlation (signed)
//   energy_in                        : per-sample scaled energy (signed)
//   out_valid                        : one-cycle pulse per search period
//   peak_idx                         : search index of the winning sample
//   peak_metric                      : metric at the peak
//   gamma_real/gamma_imag            : window correlation sums at the peak
// master drives samples and receives results; slave is the detector.
interface cp_window_peak_if
  import cp_window_peak_pkg::*;
#(
  parameter int WL_IN   = DEF_WL_IN,
  parameter int CP_LEN  = DEF_CP_LEN,
  parameter int SYM_LEN = DEF_SYM_LEN,
  parameter int WL_ACC  = WL_IN + $clog2(CP_LEN)
) ();

  logic                          in_valid;
  logic signed [WL_IN-1:0]       corr_real_in;
  logic signed [WL_IN-1:0]       corr_imag_in;
  logic signed [WL_IN-1:0]       energy_in;
  logic                          out_valid;
  logic [$clog2(SYM_LEN)-1:0]    peak_idx;
  logic signed [WL_ACC+1:0]      peak_metric;
  logic signed [WL_ACC-1:0]      gamma_real;
  logic signed [WL_ACC-1:0]      gamma_imag;

  modport master (
    output in_valid, corr_real_in, corr_imag_in, energy_in,
    input  out_valid, peak_idx, peak_metric, gamma_real, gamma_imag
  );

  modport slave (
    input  in_valid, corr_real_in, corr_imag_in, energy_in,
    output out_valid, peak_idx, peak_metric, gamma_real, gamma_imag
  );

endinterface

// File: rtl/cp_window_peak_delay.sv
// cp_delay_line: CP_LEN-deep circular buffer of (corr_real, corr_imag,
// energy) with its write pointer. The entry at the write pointer is the
// oldest sample, i.e. the one leaving the window when a new sample is
// written, and is presented combinationally on old_*.
//   clk, rst       : clock, synchronous active-high reset (pointer only)
//   wr_en          : write strobe, advances the pointer
//   din_re/im/en   : incoming sample
//   old_re/im/en   : entry about to be overwritten
// Buffer contents are not cleared by reset; the parent masks them while
// the window is filling.
module cp_delay_line
  import cp_window_peak_pkg::*;
#(
  parameter int WL_IN  = DEF_WL_IN,
  parameter int CP_LEN = DEF_CP_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic signed [WL_IN-1:0] din_re,
  input  logic signed [WL_IN-1:0] din_im,
  input  logic signed [WL_IN-1:0] din_en,
  output logic signed [WL_IN-1:0] old_re,
  output logic signed [WL_IN-1:0] old_im,
  output logic signed [WL_IN-1:0] old_en
);

  localparam int PTR_W = $clog2(CP_LEN);

  logic [PTR_W-1:0]        wr_ptr;
  logic signed [WL_IN-1:0] mem_re [CP_LEN];
  logic signed [WL_IN-1:0] mem_im [CP_LEN];
  logic signed [WL_IN-1:0] mem_en [CP_LEN];

  // CP_LEN is a power of two, so the pointer wraps on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_ptr] <= din_re;
      mem_im[wr_ptr] <= din_im;
      mem_en[wr_ptr] <= din_en;
    end
  end

  assign old_re = mem_re[wr_ptr];
  assign old_im = mem_im[wr_ptr];
  assign old_en = mem_en[wr_ptr];

endmodule

// File: rtl/cp_window_peak.sv
// cp_window_peak: sliding-window CP correlation peak search.
// Keeps running CP_LEN-sample sums of correlation (re/im) and energy,
// computes metric = |gamma| - phi per valid sample (|.| approximated as
// max + min/2) and, over each SYM_LEN-sample search period, reports the
// earliest sample with the largest metric.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cp_window_peak_if.slave (samples in, one result per period)
// Latency: a sample present in cycle t has its sums in t+1, its metric in
// t+2, and tracker/outputs in t+3. Every stage is tagged by a valid bit so
// bubbles on in_valid change nothing.
module cp_window_peak
  import cp_window_peak_pkg::*;
#(
  parameter int WL_IN   = DEF_WL_IN,
  parameter int CP_LEN  = DEF_CP_LEN,
  parameter int SYM_LEN = DEF_SYM_LEN,
  parameter int WL_ACC  = WL_IN + $clog2(CP_LEN)
) (
  input  logic clk,
  input  logic rst,
  cp_window_peak_if.slave bus
);

  localparam int PTR_W = $clog2(CP_LEN);
  localparam int IDX_W = $clog2(SYM_LEN);
  localparam int MET_W = WL_ACC + 2;

  localparam logic [PTR_W-1:0]        LAST_FILL = PTR_W'(CP_LEN - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(SYM_LEN - 1);
  localparam logic signed [MET_W-1:0] MET_MIN   = MET_W'(met_most_neg(MET_W));
  localparam logic signed [WL_ACC-1:0] ACC_MIN  = {1'b1, {(WL_ACC-1){1'b0}}};
  localparam logic [WL_ACC-1:0]        ACC_MAX  = {1'b0, {(WL_ACC-1){1'b1}}};

  // |x| with the most negative input saturated to the largest positive value.
  function automatic logic [WL_ACC-1:0] sat_abs(input logic signed [WL_ACC-1:0] x);
    if (x == ACC_MIN) return ACC_MAX;
    else if (x < 0)   return $unsigned(-x);
    else              return $unsigned(x);
  endfunction

  // metric = max(|gr|,|gi|) + min(|gr|,|gi|)/2 - phi. The magnitude fits in
  // WL_ACC+1 unsigned bits, so WL_ACC+2 signed bits cannot overflow.
  function automatic logic signed [MET_W-1:0] calc_metric(
    input logic signed [WL_ACC-1:0] gr,
    input logic signed [WL_ACC-1:0] gi,
    input logic signed [WL_ACC-1:0] phi
  );
    logic [WL_ACC-1:0] ar, ai, mx, mn;
    logic [WL_ACC:0]   mag;
    ar = sat_abs(gr);
    ai = sat_abs(gi);
    if (ar >= ai) begin
      mx = ar;
      mn = ai;
    end else begin
      mx = ai;
      mn = ar;
    end
    mag = {1'b0, mx} + {2'b00, mn[WL_ACC-1:1]};
    return $signed({1'b0, mag}) - MET_W'(phi);
  endfunction

  // Delay line and window-exit masking
  logic signed [WL_IN-1:0] old_re, old_im, old_en;
  logic signed [WL_IN-1:0] sub_re, sub_im, sub_en;

  cp_delay_line #(
    .WL_IN  (WL_IN),
    .CP_LEN (CP_LEN)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bus.in_valid),
    .din_re (bus.corr_real_in),
    .din_im (bus.corr_imag_in),
    .din_en (bus.energy_in),
    .old_re (old_re),
    .old_im (old_im),
    .old_en (old_en)
  );

  cp_state_e        state;
  logic [PTR_W-1:0] fill_cnt;
  logic [IDX_W-1:0] cnt;
  logic             eval_in;

  // While filling, the buffer may hold stale data from before a reset.
  always_comb begin
    sub_re = old_re;
    sub_im = old_im;
    sub_en = old_en;
    if (state == ST_FILL) begin
      sub_re = '0;
      sub_im = '0;
      sub_en = '0;
    end
  end

  // The CP_LEN-th fill sample completes the first window and is evaluated.
  assign eval_in = bus.in_valid && ((state == ST_SEARCH) || (fill_cnt == LAST_FILL));

  // Stage p0: running sums, FSM and search counter
  logic signed [WL_ACC-1:0] sum_re_p0, sum_im_p0, sum_en_p0;
  logic [IDX_W-1:0]         idx_p0;
  logic                     vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      cnt      <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= eval_in;
      if (bus.in_valid) begin
        case (state)
          ST_FILL: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST_FILL) state <= ST_SEARCH;
          end
          ST_SEARCH: state <= ST_SEARCH;
          default:   state <= ST_FILL;
        endcase
      end
      if (eval_in) cnt <= (cnt == IDX_LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_re_p0 <= '0;
      sum_im_p0 <= '0;
      sum_en_p0 <= '0;
    end else if (bus.in_valid) begin
      sum_re_p0 <= sum_re_p0 + WL_ACC'(bus.corr_real_in) - WL_ACC'(sub_re);
      sum_im_p0 <= sum_im_p0 + WL_ACC'(bus.corr_imag_in) - WL_ACC'(sub_im);
      sum_en_p0 <= sum_en_p0 + WL_ACC'(bus.energy_in)    - WL_ACC'(sub_en);
    end
  end

  always_ff @(posedge clk) begin
    if (eval_in) idx_p0 <= cnt;
  end

  // Stage p1: metric
  logic signed [MET_W-1:0]  metric_p1;
  logic signed [WL_ACC-1:0] gre_p1, gim_p1;
  logic [IDX_W-1:0]         idx_p1;
  logic                     vld_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      metric_p1 <= calc_metric(sum_re_p0, sum_im_p0, sum_en_p0);
      gre_p1    <= sum_re_p0;
      gim_p1    <= sum_im_p0;
      idx_p1    <= idx_p0;
    end
  end

  // Stage p2: peak tracker and registered outputs
  logic signed [MET_W-1:0]  best_met_p2;
  logic signed [WL_ACC-1:0] best_re_p2, best_im_p2;
  logic [IDX_W-1:0]         best_idx_p2;
  logic                     vld_p2;
  logic [IDX_W-1:0]         peak_idx_p2;
  logic signed [MET_W-1:0]  peak_met_p2;
  logic signed [WL_ACC-1:0] peak_re_p2, peak_im_p2;
  logic                     take;

  // Strictly greater keeps the earliest index on ties.
  assign take = metric_p1 > best_met_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2      <= 1'b0;
      best_met_p2 <= MET_MIN;
      best_re_p2  <= '0;
      best_im_p2  <= '0;
      best_idx_p2 <= '0;
      peak_idx_p2 <= '0;
      peak_met_p2 <= '0;
      peak_re_p2  <= '0;
      peak_im_p2  <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        if (idx_p1 == IDX_LAST) begin
          // Last sample of the period still competes before publishing.
          vld_p2      <= 1'b1;
          best_met_p2 <= MET_MIN;
          if (take) begin
            peak_idx_p2 <= idx_p1;
            peak_met_p2 <= metric_p1;
            peak_re_p2  <= gre_p1;
            peak_im_p2  <= gim_p1;
          end else begin
            peak_idx_p2 <= best_idx_p2;
            peak_met_p2 <= best_met_p2;
            peak_re_p2  <= best_re_p2;
            peak_im_p2  <= best_im_p2;
          end
        end else if (take) begin
          best_met_p2 <= metric_p1;
          best_re_p2  <= gre_p1;
          best_im_p2  <= gim_p1;
          best_idx_p2 <= idx_p1;
        end
      end
    end
  end

  assign bus.out_valid   = vld_p2;
  assign bus.peak_idx    = peak_idx_p2;
  assign bus.peak_metric = peak_met_p2;
  assign bus.gamma_real  = peak_re_p2;
  assign bus.gamma_imag  = peak_im_p2;

endmodule

// File: tb/tb_cp_window_peak.sv
// Directed bench for cp_window_peak: reset values, constant input, impulse,
// energy subtraction, bubbles on in_valid and a mid-search reset.
module tb_cp_window_peak;

  localparam int WL_IN   = 20;
  localparam int CP_LEN  = 16;
  localparam int SYM_LEN = 272;
  localparam int WL_ACC  = 24;
  localparam int IDX_W   = 9;
  localparam int MET_W   = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp_window_peak_if #(
    .WL_IN(WL_IN), .CP_LEN(CP_LEN), .SYM_LEN(SYM_LEN), .WL_ACC(WL_ACC)
  ) bus_i ();

  cp_window_peak #(
    .WL_IN(WL_IN), .CP_LEN(CP_LEN), .SYM_LEN(SYM_LEN), .WL_ACC(WL_ACC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int nvalid, cyc_287, pulse_cnt, first_cyc, stable_err;
  logic [IDX_W-1:0]         f_idx;
  logic signed [MET_W-1:0]  f_met;
  logic signed [WL_ACC-1:0] f_re, f_im;

  task automatic clear_rec();
    nvalid = 0; cyc_287 = -1; pulse_cnt = 0; first_cyc = -1; stable_err = 0;
    f_idx = '0; f_met = '0; f_re = '0; f_im = '0;
  endtask

  // One clock: drive inputs, wait for the edge, sample outputs 1 ns later.
  task automatic cycle(input logic v, input int cr, input int ci, input int en);
    int pres;
    bus_i.in_valid     = v;
    bus_i.corr_real_in = cr[WL_IN-1:0];
    bus_i.corr_imag_in = ci[WL_IN-1:0];
    bus_i.energy_in    = en[WL_IN-1:0];
    pres = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (v && !rst) begin
      nvalid++;
      if (nvalid == 287) cyc_287 = pres;
    end
    if (bus_i.out_valid) begin
      pulse_cnt++;
      if (pulse_cnt == 1) begin
        first_cyc = cyc;
        f_idx = bus_i.peak_idx; f_met = bus_i.peak_metric;
        f_re = bus_i.gamma_real; f_im = bus_i.gamma_imag;
      end
    end else if (pulse_cnt > 0 &&
                 (bus_i.peak_idx !== f_idx || bus_i.peak_metric !== f_met ||
                  bus_i.gamma_real !== f_re || bus_i.gamma_imag !== f_im)) begin
      stable_err++;
    end
  endtask

  // mode 0: constant 100/0/0, 1: impulse 1000 at valid sample 50,
  // 2: -300/+400 with energy 200. alt inserts a bubble after every sample.
  task automatic run_stream(input int mode, input bit alt, input int nv);
    int k;
    for (int it = 0; it < 4 * nv + 8 && nvalid < nv; it++) begin
      k = nvalid;
      case (mode)
        0:       cycle(1'b1, 100, 0, 0);
        1:       cycle(1'b1, (k == 50) ? 1000 : 0, 0, 0);
        default: cycle(1'b1, -300, 400, 200);
      endcase
      if (alt) cycle(1'b0, 7777, -5555, 3333);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 123, 45, 6);
    rst = 1'b0;
    clear_rec();
  endtask

  task automatic test_reset();
    clear_rec();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 500 + i, -200, 17);
    n_chk++; if (bus_i.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus_i.out_valid); else n_pass++;
    n_chk++; if (bus_i.peak_idx !== '0) $display("FAIL reset_peak_idx got %0d want 0", bus_i.peak_idx); else n_pass++;
    n_chk++; if (bus_i.peak_metric !== '0) $display("FAIL reset_peak_metric got %0d want 0", bus_i.peak_metric); else n_pass++;
    n_chk++; if (bus_i.gamma_real !== '0) $display("FAIL reset_gamma_real got %0d want 0", bus_i.gamma_real); else n_pass++;
    n_chk++; if (bus_i.gamma_imag !== '0) $display("FAIL reset_gamma_imag got %0d want 0", bus_i.gamma_imag); else n_pass++;
    rst = 1'b0;
    clear_rec();
  endtask

  task automatic test_constant();
    do_reset();
    run_stream(0, 1'b0, 290);
    drain(5);
    n_chk++; if (first_cyc !== cyc_287 + 3) $display("FAIL const_latency got cycle %0d want %0d", first_cyc, cyc_287 + 3); else n_pass++;
    n_chk++; if (pulse_cnt !== 1) $display("FAIL const_pulses got %0d want 1", pulse_cnt); else n_pass++;
    n_chk++; if (f_idx !== 9'd0) $display("FAIL const_idx got %0d want 0", f_idx); else n_pass++;
    n_chk++; if (f_met !== 26'sd1600) $display("FAIL const_metric got %0d want 1600", f_met); else n_pass++;
    n_chk++; if (f_re !== 24'sd1600) $display("FAIL const_gamma_real got %0d want 1600", f_re); else n_pass++;
    n_chk++; if (f_im !== 24'sd0) $display("FAIL const_gamma_imag got %0d want 0", f_im); else n_pass++;
    n_chk++; if (stable_err !== 0) $display("FAIL const_hold got %0d changes want 0", stable_err); else n_pass++;
  endtask

  task automatic test_impulse();
    do_reset();
    run_stream(1, 1'b0, 290);
    drain(5);
    n_chk++; if (pulse_cnt !== 1) $display("FAIL imp_pulses got %0d want 1", pulse_cnt); else n_pass++;
    n_chk++; if (f_idx !== 9'd35) $display("FAIL imp_idx got %0d want 35", f_idx); else n_pass++;
    n_chk++; if (f_met !== 26'sd1000) $display("FAIL imp_metric got %0d want 1000", f_met); else n_pass++;
    n_chk++; if (f_re !== 24'sd1000) $display("FAIL imp_gamma_real got %0d want 1000", f_re); else n_pass++;
    n_chk++; if (f_im !== 24'sd0) $display("FAIL imp_gamma_imag got %0d want 0", f_im); else n_pass++;
  endtask

  task automatic test_energy();
    do_reset();
    run_stream(2, 1'b0, 290);
    drain(5);
    n_chk++; if (f_re !== -24'sd4800) $display("FAIL en_gamma_real got %0d want -4800", f_re); else n_pass++;
    n_chk++; if (f_im !== 24'sd6400) $display("FAIL en_gamma_imag got %0d want 6400", f_im); else n_pass++;
    n_chk++; if (f_met !== 26'sd5600) $display("FAIL en_metric got %0d want 5600", f_met); else n_pass++;
    n_chk++; if (f_idx !== 9'd0) $display("FAIL en_idx got %0d want 0", f_idx); else n_pass++;
    n_chk++; if (first_cyc !== cyc_287 + 3) $display("FAIL en_latency got cycle %0d want %0d", first_cyc, cyc_287 + 3); else n_pass++;
  endtask

  task automatic test_bubbles();
    do_reset();
    run_stream(1, 1'b1, 290);
    drain(5);
    n_chk++; if (first_cyc !== cyc_287 + 3) $display("FAIL bub_latency got cycle %0d want %0d", first_cyc, cyc_287 + 3); else n_pass++;
    n_chk++; if (pulse_cnt !== 1) $display("FAIL bub_pulses got %0d want 1", pulse_cnt); else n_pass++;
    n_chk++; if (f_idx !== 9'd35) $display("FAIL bub_idx got %0d want 35", f_idx); else n_pass++;
    n_chk++; if (f_met !== 26'sd1000) $display("FAIL bub_metric got %0d want 1000", f_met); else n_pass++;
    n_chk++; if (f_re !== 24'sd1000) $display("FAIL bub_gamma_real got %0d want 1000", f_re); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    // 116 samples: 16 fill plus search indices 0..100.
    run_stream(0, 1'b0, 116);
    do_reset();
    drain(4);
    n_chk++; if (pulse_cnt !== 0) $display("FAIL mid_stale_pulse got %0d pulses want 0", pulse_cnt); else n_pass++;
    run_stream(0, 1'b0, 286);
    drain(4);
    n_chk++; if (pulse_cnt !== 0) $display("FAIL mid_early_pulse got %0d pulses want 0", pulse_cnt); else n_pass++;
    run_stream(0, 1'b0, 290);
    drain(5);
    n_chk++; if (first_cyc !== cyc_287 + 3) $display("FAIL mid_latency got cycle %0d want %0d", first_cyc, cyc_287 + 3); else n_pass++;
    n_chk++; if (f_idx !== 9'd0) $display("FAIL mid_idx got %0d want 0", f_idx); else n_pass++;
    n_chk++; if (f_met !== 26'sd1600) $display("FAIL mid_metric got %0d want 1600", f_met); else n_pass++;
    n_chk++; if (f_re !== 24'sd1600) $display("FAIL mid_gamma_real got %0d want 1600", f_re); else n_pass++;
  endtask

  initial begin
    bus_i.in_valid = 1'b0;
    bus_i.corr_real_in = '0;
    bus_i.corr_imag_in = '0;
    bus_i.energy_in = '0;
    test_reset();
    test_constant();
    test_impulse();
    test_energy();
    test_bubbles();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cp_window_peak.md
CP_WINDOW_PEAK -- requirements
Module: cp_window_peak

Interface
REQ-001 SHALL have parameter WL_IN, default 20, width of incoming correlation and energy terms.
REQ-002 SHALL have parameter CP_LEN, default 16, sliding-window length in samples; power of two.
REQ-003 SHALL have parameter SYM_LEN, default 272, search-period length in samples (FFT size plus CP).
REQ-004 SHALL have parameter WL_ACC, default WL_IN+log2(CP_LEN), window-sum width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, sample strobe from the metric precalc stage.
REQ-008 SHALL have ports corr_real_in, corr_imag_in, energy_in, input, signed WL_IN, per-sample correlation and scaled energy.
REQ-009 SHALL have port out_valid, output, 1, one-cycle result pulse per search period.
REQ-010 SHALL have port peak_idx, output, clog2(SYM_LEN), search index of the winning sample.
REQ-011 SHALL have port peak_metric, output, signed WL_ACC+2, metric value at the peak.
REQ-012 SHALL have ports gamma_real, gamma_imag, output, signed WL_ACC, window correlation sums at the peak.

Function
REQ-013 SHALL keep a CP_LEN-deep circular buffer of (corr_real, corr_imag, energy), written at the write pointer and advanced only on in_valid.
REQ-014 SHALL update three running sums per valid sample as S <= S + x_new - x_old, with x_old being the buffer entry overwritten; x_old is forced to 0 while in FILL.
REQ-015 SHALL use states FILL (reset) and SEARCH; FILL counts valid samples, and the CP_LEN-th valid sample moves to SEARCH and is itself evaluated as search index 0.
REQ-016 SHALL compute magnitude as max(|gr|,|gi|) + min(|gr|,|gi|)>>1, with |most negative| saturated to the maximum positive value, and metric = magnitude - phi_sum, in WL_ACC+2 signed bits without overflow.
REQ-017 SHALL pipeline the datapath as: sample accepted in cycle t; sums registered at t+1; metric registered at t+2; tracker and outputs registered at t+3.
REQ-018 SHALL advance the pipeline only for valid samples; bubbles in in_valid SHALL NOT alter sums, counters or the tracker.
REQ-019 SHALL keep search counter cnt in 0..SYM_LEN-1, incremented per evaluated sample and wrapping to 0 after SYM_LEN-1.
REQ-020 SHALL replace the stored best only when metric is strictly greater; on ties the earliest index is kept.
REQ-021 SHALL, on evaluating cnt==SYM_LEN-1 (the sample is included in the comparison), pulse out_valid for exactly one cycle with peak_idx, peak_metric, gamma_real and gamma_imag, and SHALL reset best to the most negative value for the next period.
REQ-022 SHALL hold peak outputs stable between out_valid pulses.
REQ-023 SHALL keep the sliding sums continuous across period boundaries; there is no refill after the first FILL.

Reset
REQ-024 SHALL clear on rst: out_valid, peak_idx, peak_metric, gamma_real and gamma_imag to 0; sums, pointers and counters to 0; best to most negative; state to FILL; pipeline valids to 0.
REQ-025 SHALL, on rst mid-operation, discard in-flight samples, produce no out_valid, and restart with a full CP_LEN FILL; buffer contents SHALL NOT be cleared, since they are masked by REQ-014.

Structure
REQ-026 SHALL take parameter defaults, the metric type and the most-negative constant from the shared receiver package.
REQ-027 SHALL isolate the circular buffer and its pointer in sub-module cp_delay_line; sums, FSM and tracker stay in cp_window_peak.

Verification
REQ-028 SHALL check reset: with rst high, all outputs are 0 and out_valid stays low until 287 valid samples have followed deassertion.
REQ-029 SHALL check constant input (corr_real 100, imag 0, energy 0, in_valid continuous): first out_valid 3 cycles after the 287th sample, with peak_idx 0, gamma_real 1600, gamma_imag 0 and peak_metric 1600.
REQ-030 SHALL check an impulse (corr_real 1000 at absolute sample 50, all else 0): peak_idx 35, peak_metric 1000, gamma_real 1000.
REQ-031 SHALL check energy subtraction (corr -300/+400 and energy 200, both constant): gamma -4800/6400, magnitude 8800, peak_metric 5600, peak_idx 0.
REQ-032 SHALL check the REQ-030 stimulus with in_valid alternating 1/0: results are identical and out_valid appears only after the 287th valid sample.
REQ-033 SHALL check reset asserted at search sample 100 followed by constant input: no stale pulse, and the next out_valid occurs after 287 new valid samples with REQ-029 values.
